// File: rtl/jogo_pkg.sv
// Shared definitions for the game controller.
//   - estado_t   : 4-bit FSM state encodings driven onto state_f
//   - PREMIO_*   : last-winner codes driven onto premio_f
//   - DIG_W      : width of one BCD digit
//   - SCORE_W    : width of each score bus
//   - digito_igual() : BCD digit compare that rejects values above 9
package jogo_pkg;

    localparam int DIG_W   = 4;
    localparam int SCORE_W = 5;

    typedef enum logic [3:0] {
        s0  = 4'b0000,
        s1  = 4'b0001,
        s2  = 4'b0010,
        s3  = 4'b0011,
        s4  = 4'b0100,
        sg1 = 4'b0101,
        sg2 = 4'b0110,
        sg0 = 4'b0111,
        sgx = 4'b1000
    } estado_t;

    localparam logic [1:0] PREMIO_NONE = 2'b00;
    localparam logic [1:0] PREMIO_P1   = 2'b01;
    localparam logic [1:0] PREMIO_P2   = 2'b10;

    // A non-BCD digit never matches, even if the secret code itself were
    // (mis)configured with a non-BCD nibble.
    function automatic logic digito_igual(input logic [DIG_W-1:0] d,
                                          input logic [DIG_W-1:0] r);
        return (d <= DIG_W'(9)) && (d == r);
    endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector for a level input.
//   clk, rst : clock, asynchronous active-high reset
//   sinal    : level input (already synchronous to clk)
//   borda    : one-cycle pulse on the cycle where sinal goes 0 -> 1
// A level held high produces exactly one pulse.
module detector_borda (
    input  logic clk,
    input  logic rst,
    input  logic sinal,
    output logic borda
);

    logic sinal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sinal_q <= 1'b0;
        else     sinal_q <= sinal;
    end

    assign borda = sinal & ~sinal_q;

endmodule

// File: rtl/controle_jogo.sv
// Two-player code-entry game controller.
//   clk, rst  : clock, asynchronous active-high reset
//   digito    : BCD digit from switches
//   confirma  : confirm key (level; only its rising edge acts)
//   cancela   : abort current entry (level, honoured in s1..s4)
//   jogador   : 0 = player 1, 1 = player 2 (sampled on the first digit)
//   state_f   : current FSM state encoding
//   premio_f  : last winner (00 none, 01 player 1, 10 player 2)
//   p1_f/p2_f : saturating player scores
// All outputs come straight from registers.
module controle_jogo
    import jogo_pkg::*;
#(
    parameter logic [15:0] CODE        = 16'h1234,
    parameter int          HOLD_CYCLES = 4,
    parameter int          SCORE_MAX   = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIG_W-1:0]   digito,
    input  logic               confirma,
    input  logic               cancela,
    input  logic               jogador,
    output logic [3:0]         state_f,
    output logic [1:0]         premio_f,
    output logic [SCORE_W-1:0] p1_f,
    output logic [SCORE_W-1:0] p2_f
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    // digit 0 is the most significant nibble of CODE
    localparam logic [DIG_W-1:0] D0 = CODE[15:12];
    localparam logic [DIG_W-1:0] D1 = CODE[11:8];
    localparam logic [DIG_W-1:0] D2 = CODE[7:4];
    localparam logic [DIG_W-1:0] D3 = CODE[3:0];

    estado_t            state;
    logic [3:0]         m;
    logic               jog;
    logic [CNT_W-1:0]   cnt;
    logic               ev;

    detector_borda u_borda (
        .clk   (clk),
        .rst   (rst),
        .sinal (confirma),
        .borda (ev)
    );

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v >= SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= s0;
            m        <= '0;
            jog      <= 1'b0;
            cnt      <= '0;
            premio_f <= PREMIO_NONE;
            p1_f     <= '0;
            p2_f     <= '0;
        end else begin
            case (state)
                s0: if (ev) begin
                    jog   <= jogador;
                    m[0]  <= digito_igual(digito, D0);
                    state <= s1;
                end
                // cancela outranks a simultaneous confirm edge
                s1: if (cancela) begin
                    m     <= '0;
                    state <= s0;
                end else if (ev) begin
                    m[1]  <= digito_igual(digito, D1);
                    state <= s2;
                end
                s2: if (cancela) begin
                    m     <= '0;
                    state <= s0;
                end else if (ev) begin
                    m[2]  <= digito_igual(digito, D2);
                    state <= s3;
                end
                s3: if (cancela) begin
                    m     <= '0;
                    state <= s0;
                end else if (ev) begin
                    m[3]  <= digito_igual(digito, D3);
                    state <= s4;
                end
                s4: if (cancela) begin
                    m     <= '0;
                    state <= s0;
                end else if (ev) begin
                    if (&m) state <= jog ? sg2 : sg1;
                    else    state <= sg0;
                end
                // score/prize are written on the way out of sg1/sg2 so they
                // are already visible in the first sgx cycle
                sg1: begin
                    p1_f     <= sat_inc(p1_f);
                    premio_f <= PREMIO_P1;
                    cnt      <= '0;
                    state    <= sgx;
                end
                sg2: begin
                    p2_f     <= sat_inc(p2_f);
                    premio_f <= PREMIO_P2;
                    cnt      <= '0;
                    state    <= sgx;
                end
                sg0: begin
                    cnt   <= '0;
                    state <= sgx;
                end
                // counter starts at 0 on entry, so the last sgx cycle is
                // the one holding HOLD_CYCLES-1
                sgx: if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    cnt   <= '0;
                    state <= s0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= s0;
            endcase
        end
    end

    assign state_f = state;

endmodule
